ps2_keymap_decoder: RTL and testbench
=====================================

PS2_KEYMAP_DECODER -- requirements
Module: ps2_keymap_decoder

Interface
REQ-001 The parameter NUM_KEYS SHALL default to 16 and give the number of tracked keys, legal range 1..64.
REQ-002 The parameter KEY_CODES SHALL be a NUM_KEYS*9-bit vector, one 9-bit entry per key: bit8 = E0-extended flag, bits7:0 = scan code; entry i maps to output bit i.
REQ-003 The parameter TIMEOUT_CYCLES SHALL default to 2_500_000 (50 ms at 50 MHz) and set the prefix-abandon timeout.
REQ-004 clk  input  1  system clock; the block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rx_data  input  8  received PS/2 byte, sampled only when rx_valid=1.
REQ-007 rx_valid  input  1  single-cycle strobe marking a new rx_data byte.
REQ-008 held  output  NUM_KEYS  level per key: 1 while the key is down.
REQ-009 press  output  NUM_KEYS  one-cycle pulse per key on a real up->down transition.
REQ-010 release  output  NUM_KEYS  one-cycle pulse per key on a down->up transition.
REQ-011 any_held  output  1  OR-reduction of held, registered with held.
REQ-012 last_code  output  9  {ext, code} of the most recent completed make or break, mapped or not.

Function
REQ-013 The parser SHALL be an FSM with states IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), SKIP (pause sequence).
REQ-014 Transitions on rx_valid: IDLE: E0->EXT, F0->BRK, E1->SKIP, else make{0,byte}->IDLE; EXT: F0->EXT_BRK, else make{1,byte}->IDLE; BRK: break{0,byte}->IDLE; EXT_BRK: break{1,byte}->IDLE.
REQ-015 SKIP SHALL discard the next 7 bytes with a 3-bit counter, then return to IDLE, producing no make/break.
REQ-016 A make SHALL set held[i] for every i whose KEY_CODES entry equals the 9-bit code; duplicate entries all update.
REQ-017 press[i] SHALL pulse only if held[i] was 0; typematic repeats of a held key SHALL produce no pulse.
REQ-018 A break SHALL clear held[i] for matching i; release[i] SHALL pulse only if held[i] was 1.
REQ-019 Latency: held/press/release/last_code SHALL update on the clock edge after the final byte's rx_valid cycle (1 cycle).
REQ-020 press and release SHALL be zero in all cycles without a completed make/break.
REQ-021 Unmapped codes SHALL update last_code only; held unchanged.
REQ-022 In EXT, BRK, EXT_BRK or SKIP, TIMEOUT_CYCLES clocks without rx_valid SHALL force IDLE with no key effect; the timer restarts on every rx_valid.
REQ-023 rx_valid is ignored while reset=1; bytes arriving on consecutive cycles SHALL each be processed.

Reset
REQ-024 reset=1 SHALL asynchronously force state IDLE, skip counter 0, timeout counter 0, held/press/release 0, any_held 0, last_code 9'h000.
REQ-025 Reset mid-sequence SHALL discard the partial sequence; the next byte is parsed from IDLE.

Structure
REQ-026 Shared package ps2_pkg SHALL hold prefix constants (8'hE0, 8'hF0, 8'hE1), the FSM state encoding and the pause-sequence length 7.
REQ-027 The timeout counter SHALL be a sub-module ps2_idle_timer (clk, reset, restart, active, expired).
REQ-028 Key matching SHALL be a generate loop of NUM_KEYS 9-bit comparators; no per-key FSMs.

Verification (NUM_KEYS=3, KEY_CODES = {9'h029, 9'h175, 9'h01D}; index0=W, index1=Up, index2=Space)
REQ-029 1D -> held=3'b001, press=3'b001 one cycle; 1D 1D -> no further press; F0 1D -> held=0, release=3'b001 one cycle.
REQ-030 E0 75 -> held[1]=1, last_code=9'h175; plain 75 -> no change to held[1]; E0 F0 75 -> release[1] pulse.
REQ-031 E1 14 77 E1 F0 14 F0 77 with KEY_CODES entry 9'h014 added -> held unchanged, FSM back in IDLE, next 1D sets held[0].
REQ-032 E0 then TIMEOUT_CYCLES idle, then 29 -> held[2]=1 (non-extended), not treated as extended.
REQ-033 F0 received, reset pulsed, then 1D -> held[0]=1 (not a break); all outputs 0 during reset.
REQ-034 F0 1D while held[0]=0 -> no release pulse, held stays 0, last_code=9'h01D.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 prefix bytes, parser state encoding and pause-sequence length.
package ps2_pkg;
    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;
    localparam logic [7:0] PFX_PAUSE = 8'hE1;
    localparam int         PAUSE_LEN = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } state_t;
endpackage

// File: rtl/ps2_idle_timer.sv
// ps2_idle_timer: flags a prefix left dangling for TIMEOUT_CYCLES clocks without a new byte.
module ps2_idle_timer #(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic active,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] cnt;

    assign expired = active && cnt == W'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else
            cnt <= (restart || !active || expired) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/ps2_keymap_decoder.sv
// ps2_keymap_decoder: parses PS/2 set-2 make/break sequences and tracks a table of keys.
module ps2_keymap_decoder
    import ps2_pkg::*;
#(
    parameter int                    NUM_KEYS       = 16,
    parameter logic [NUM_KEYS*9-1:0] KEY_CODES      = '0,
    parameter int                    TIMEOUT_CYCLES = 2_500_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [NUM_KEYS-1:0] held,
    output logic [NUM_KEYS-1:0] press,
    output logic [NUM_KEYS-1:0] released,
    output logic                any_held,
    output logic [8:0]          last_code
);
    state_t              state;
    logic [2:0]          skip_cnt;
    logic                expired, done, brk;
    logic [8:0]          code;
    logic [NUM_KEYS-1:0] hit, make_v, brk_v, held_nxt;

    ps2_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .restart (rx_valid),
        .active  (state != ST_IDLE),
        .expired (expired)
    );

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_match
        assign hit[k] = KEY_CODES[k*9 +: 9] == code;
    end

    always_comb begin
        brk      = state == ST_BRK || state == ST_EXT_BRK;
        code     = {state == ST_EXT || state == ST_EXT_BRK, rx_data};
        done     = rx_valid && (state == ST_IDLE ? !(rx_data inside {PFX_EXT, PFX_BRK, PFX_PAUSE}) :
                                state == ST_EXT  ? rx_data != PFX_BRK : brk);
        make_v   = done && !brk ? hit : '0;
        brk_v    = done && brk ? hit : '0;
        held_nxt = (held | make_v) & ~brk_v;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            skip_cnt  <= '0;
            held      <= '0;
            press     <= '0;
            released  <= '0;
            any_held  <= 1'b0;
            last_code <= '0;
        end else begin
            if (rx_valid) begin
                unique case (state)
                    ST_IDLE: state <= rx_data == PFX_EXT ? ST_EXT : rx_data == PFX_BRK ? ST_BRK :
                                      rx_data == PFX_PAUSE ? ST_SKIP : ST_IDLE;
                    ST_EXT:  state <= rx_data == PFX_BRK ? ST_EXT_BRK : ST_IDLE;
                    ST_SKIP: begin
                        skip_cnt <= skip_cnt == 3'(PAUSE_LEN - 1) ? 3'd0 : skip_cnt + 3'd1;
                        state    <= skip_cnt == 3'(PAUSE_LEN - 1) ? ST_IDLE : ST_SKIP;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (expired) begin
                state    <= ST_IDLE;
                skip_cnt <= '0;
            end
            held     <= held_nxt;
            any_held <= |held_nxt;
            press    <= make_v & ~held;
            released <= brk_v & held;
            if (done)
                last_code <= code;
        end
    end
endmodule

// File: tb/tb_ps2_keymap_decoder.sv
// tb_ps2_keymap_decoder: directed and random byte streams checked against a sequence-level key model.
module tb_ps2_keymap_decoder;
    localparam int NK = 4;
    localparam int TO = 20;
    localparam logic [NK*9-1:0] KC = {9'h014, 9'h029, 9'h175, 9'h01D};

    logic          clk = 1'b0, reset = 1'b1, rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic [NK-1:0] held, press, released;
    logic          any_held;
    logic [8:0]    last_code;

    int compared = 0, mismatched = 0;

    logic [8:0]    keys [NK] = '{9'h01D, 9'h175, 9'h029, 9'h014};
    logic [NK-1:0] m_held = '0, m_press = '0, m_rel = '0;
    logic [8:0]    m_last = '0;
    logic [7:0]    seq [$];
    int            skip_left = 0, idle = 0;
    logic [7:0]    pool [9] = '{8'h1D, 8'h75, 8'h29, 8'h14, 8'h77, 8'hE0, 8'hF0, 8'hE1, 8'h00};

    always #5 clk = ~clk;

    ps2_keymap_decoder #(.NUM_KEYS(NK), .KEY_CODES(KC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .held(held), .press(press), .released(released), .any_held(any_held), .last_code(last_code)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A byte either extends the pending prefix list or completes it into one make/break.
    function automatic void model_byte(input logic [7:0] b);
        logic ext, brk;
        idle = 0;
        if (skip_left > 0) begin
            skip_left--;
            return;
        end
        seq.push_back(b);
        if (seq.size() == 1 && b == 8'hE1) begin
            seq.delete();
            skip_left = 7;
            return;
        end
        if ((seq.size() == 1 && (b == 8'hE0 || b == 8'hF0)) || (seq.size() == 2 && seq[0] == 8'hE0 && b == 8'hF0))
            return;
        ext = seq[0] == 8'hE0;
        brk = seq.size() > 1 && seq[seq.size()-2] == 8'hF0;
        m_last = {ext, b};
        for (int i = 0; i < NK; i++)
            if (keys[i] == {ext, b}) begin
                if (brk) begin
                    m_rel[i] = m_held[i];
                    m_held[i] = 1'b0;
                end else begin
                    m_press[i] = !m_held[i];
                    m_held[i] = 1'b1;
                end
            end
        seq.delete();
    endfunction

    task automatic check_all();
        chk("held", 64'(held), 64'(m_held));
        chk("press", 64'(press), 64'(m_press));
        chk("release", 64'(released), 64'(m_rel));
        chk("any_held", 64'(any_held), 64'(|m_held));
        chk("last_code", 64'(last_code), 64'(m_last));
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        m_press = '0;
        m_rel   = '0;
        if (v)
            model_byte(d);
        else if (seq.size() > 0 || skip_left > 0) begin
            idle++;
            if (idle == TO) begin
                seq.delete();
                skip_left = 0;
                idle = 0;
            end
        end
        #1;
        rx_valid = 1'b0;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        m_held = '0; m_press = '0; m_rel = '0; m_last = '0;
        seq.delete();
        skip_left = 0;
        idle = 0;
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #3;
        check_all();
        @(negedge clk);
        reset = 1'b0;
        step(1, 8'h1D); chk("w_held", 64'(held), 64'h1); chk("w_press", 64'(press), 64'h1);
        step(0, 0);     chk("w_press_gone", 64'(press), 64'h0);
        step(1, 8'h1D); step(1, 8'h1D); chk("typematic", 64'(press), 64'h0);
        step(1, 8'hF0); step(1, 8'h1D); chk("w_release", 64'(released), 64'h1);
        step(1, 8'hE0); step(1, 8'h75); chk("up_held", 64'(held[1]), 64'h1); chk("up_code", 64'(last_code), 64'h175);
        step(1, 8'h75); chk("plain75", 64'(held[1]), 64'h1);
        step(1, 8'hE0); step(1, 8'hF0); step(1, 8'h75); chk("up_release", 64'(released), 64'h2);
        foreach (pool[i]) if (i < 8) step(1, i == 0 ? 8'hE1 : i == 1 ? 8'h14 : i == 2 ? 8'h77 : i == 3 ? 8'hE1 :
                                               i == 4 ? 8'hF0 : i == 5 ? 8'h14 : i == 6 ? 8'hF0 : 8'h77);
        chk("pause_held", 64'(held), 64'h0);
        step(1, 8'h1D); chk("after_pause", 64'(held), 64'h1);
        step(1, 8'hF0); step(1, 8'h1D);
        step(1, 8'hE0); repeat (TO) step(0, 0); step(1, 8'h29);
        chk("timeout_space", 64'(held[2]), 64'h1); chk("timeout_code", 64'(last_code), 64'h029);
        step(1, 8'hE0); repeat (TO - 1) step(0, 0); step(1, 8'h75); chk("no_timeout_up", 64'(held[1]), 64'h1);
        step(1, 8'hF0); do_reset(); step(1, 8'h1D); chk("reset_brk", 64'(held[0]), 64'h1);
        step(1, 8'hF0); step(1, 8'h1D);
        step(1, 8'hF0); step(1, 8'h1D); chk("spurious_rel", 64'(released), 64'h0); chk("spurious_code", 64'(last_code), 64'h01D);
        for (int n = 0; n < 600; n++) begin
            int r;
            int idx;
            r = $urandom_range(0, 99);
            idx = $urandom_range(0, 8);
            if (r < 2) do_reset();
            else if (r < 6) repeat ($urandom_range(TO - 2, TO + 2)) step(0, 0);
            else if (r < 25) step(0, 0);
            else step(1, idx == 8 ? 8'($urandom) : pool[idx]);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
